// File: rtl/fl_io_pkg.sv
// Shared definitions for the float-core I/O bridge.
//   fw()        : core float width from mantissa/exponent bit counts
//   aw()        : channel address width (at least 1 bit, so one-channel builds stay legal)
//   chan_stat_t : valid/ready status of one buffered handshake channel
package fl_io_pkg;

    function automatic int fw(input int nbmant, input int nbexpo);
        return nbmant + nbexpo + 1;
    endfunction

    function automatic int aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NUIOIN_DEF = 4;
    localparam int NUIOOU_DEF = 4;
    localparam int AWI_DEF    = aw(NUIOIN_DEF);
    localparam int AWO_DEF    = aw(NUIOOU_DEF);

    typedef struct packed {
        logic vld;
        logic rdy;
    } chan_stat_t;

endpackage

// File: rtl/fl_io_chan.sv
// One-word buffered handshake channel: holding register plus valid flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : write data_i into the register (caller asserts only when rdy_o)
//   consume_i  : current word is taken this cycle
//   data_o     : held word
//   vld_o      : register holds a word
//   rdy_o      : a load would be accepted this cycle (empty, or being consumed)
module fl_io_chan
    import fl_io_pkg::*;
#(
    parameter int W = 28
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         consume_i,
    output logic [W-1:0] data_o,
    output logic         vld_o,
    output logic         rdy_o
);

    logic         vld_q, vld_d;
    logic [W-1:0] data_q, data_d;
    chan_stat_t   st;

    always_comb begin
        st.vld = vld_q;
        st.rdy = ~vld_q | consume_i;
        vld_d  = load_i | (vld_q & ~consume_i);
        data_d = load_i ? data_i : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign data_o = data_q;
    assign vld_o  = st.vld;
    assign rdy_o  = st.rdy;

endmodule

// File: rtl/float2int.sv
// Core float to signed integer conversion (combinational).
// Magnitude is truncated toward zero; results beyond the OWID signed range saturate.
//   in_i  : core float, FW bits
//   out_o : signed integer, OWID bits
module float2int
    import fl_io_pkg::*;
#(
    parameter  int NBMANT = 19,
    parameter  int NBEXPO = 8,
    parameter  int OWID   = 28,
    localparam int FW     = fw(NBMANT, NBEXPO),
    localparam int W2     = NBMANT + OWID
) (
    input  logic [FW-1:0]   in_i,
    output logic [OWID-1:0] out_o
);

    logic                     sgn;
    logic signed [NBEXPO-1:0] ex;
    logic [NBMANT-1:0]        mant;
    int                       sh;
    logic [W2-1:0]            mag;
    logic [W2-1:0]            lim;

    always_comb begin
        sgn  = in_i[FW-1];
        ex   = in_i[FW-2:NBMANT];
        mant = in_i[NBMANT-1:0];
        sh   = int'(ex);
        // Negative results may reach one step further than positive ones.
        lim  = (W2'(1) << (OWID - 1)) - (sgn ? W2'(0) : W2'(1));
        if (mant == '0)          mag = '0;
        else if (sh < 0)         mag = (-sh >= NBMANT) ? '0 : (W2'(mant) >> (-sh));
        else if (sh >= OWID)     mag = lim;
        else                     mag = W2'(mant) << sh;
        if (mag > lim) mag = lim;
        out_o = sgn ? (~mag[OWID-1:0] + OWID'(1)) : mag[OWID-1:0];
    end

endmodule

// File: rtl/int2float.sv
// Signed integer to core float conversion (combinational).
// Float layout is {sign, exponent, mantissa}: value = (-1)^sign * mantissa * 2^exponent,
// exponent in two's complement, mantissa normalised so its MSB is set; zero is all-zero.
//   in_i  : signed integer, IWID bits
//   out_o : core float, FW bits
module int2float
    import fl_io_pkg::*;
#(
    parameter  int IWID   = 19,
    parameter  int NBMANT = 19,
    parameter  int NBEXPO = 8,
    localparam int FW     = fw(NBMANT, NBEXPO)
) (
    input  logic [IWID-1:0] in_i,
    output logic [FW-1:0]   out_o
);

    logic              sgn;
    logic [IWID-1:0]   mag;
    logic [NBMANT-1:0] mant;
    int unsigned       msb;
    int                ex;

    always_comb begin
        sgn = in_i[IWID-1];
        // Most-negative input still fits as an unsigned magnitude.
        mag = sgn ? (~in_i + IWID'(1)) : in_i;
        msb = 0;
        for (int unsigned k = 0; k < IWID; k++) begin
            if (mag[k]) msb = k;
        end
        // Park the leading one at mantissa MSB; excess low bits are truncated.
        mant = NBMANT'({mag, {NBMANT{1'b0}}} >> (msb + 1));
        ex   = int'(msb) - (NBMANT - 1);
        if (mag == '0) out_o = '0;
        else           out_o = {sgn, NBEXPO'(ex), mant};
    end

endmodule

// File: rtl/fl_io_bridge.sv
// Multi-channel I/O bridge between the float core and external integer ports.
//   clk, rst                : clock, asynchronous active-low reset
//   ext_in_data/vld/rdy     : per-channel input handshake, channel i at [i*IWID +: IWID]
//   proc_req_in/addr_in     : core read request and channel
//   proc_in_data            : float word for the read (0 for a nonexistent channel)
//   proc_out_en/addr_out/.. : core write request, channel and float word
//   proc_stall              : core must hold its request and retry
//   ext_out_data/vld/rdy    : per-channel output handshake, channel j at [j*OWID +: OWID]
//   addr_err                : sticky flag, a request addressed a nonexistent channel
module fl_io_bridge
    import fl_io_pkg::*;
#(
    parameter  int NBMANT = 19,
    parameter  int NBEXPO = 8,
    parameter  int NUIOIN = 4,
    parameter  int NUIOOU = 4,
    parameter  int IWID   = 19,
    parameter  int OWID   = 28,
    parameter  int CONV   = 1,
    localparam int FW     = fw(NBMANT, NBEXPO),
    localparam int AWI    = aw(NUIOIN),
    localparam int AWO    = aw(NUIOOU)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUIOIN*IWID-1:0] ext_in_data,
    input  logic [NUIOIN-1:0]      ext_in_vld,
    output logic [NUIOIN-1:0]      ext_in_rdy,
    input  logic                   proc_req_in,
    input  logic [AWI-1:0]         proc_addr_in,
    output logic [FW-1:0]          proc_in_data,
    input  logic                   proc_out_en,
    input  logic [AWO-1:0]         proc_addr_out,
    input  logic [FW-1:0]          proc_out_data,
    output logic                   proc_stall,
    output logic [NUIOOU*OWID-1:0] ext_out_data,
    output logic [NUIOOU-1:0]      ext_out_vld,
    input  logic [NUIOOU-1:0]      ext_out_rdy,
    output logic                   addr_err
);

    if (CONV == 0 && (IWID != FW || OWID != FW)) begin : g_cfg_err
        $error("fl_io_bridge: CONV=0 requires IWID == OWID == FW");
    end

    logic [NUIOIN-1:0] in_vld, in_rdy, in_load, rd_en;
    logic [FW-1:0]     in_word [NUIOIN];
    logic [NUIOOU-1:0] out_vld, out_rdy, out_drain, wr_en;
    logic [OWID-1:0]   out_word [NUIOOU];

    logic          in_ok, out_ok, in_sel_vld, out_sel_rdy;
    logic          read_stall, write_stall, stall, go, err_hit;
    logic [FW-1:0] in_sel_data;
    logic          addr_err_q, addr_err_d;

    // Ready is held low throughout reset even though the valid flags are already clear.
    assign ext_in_rdy = in_rdy & {NUIOIN{rst}};
    assign in_load    = ext_in_vld & ext_in_rdy;
    assign out_drain  = out_vld & ext_out_rdy;

    for (genvar i = 0; i < NUIOIN; i++) begin : g_in
        logic [FW-1:0] cvt;
        if (CONV != 0) begin : g_cv
            int2float #(.IWID(IWID), .NBMANT(NBMANT), .NBEXPO(NBEXPO)) u_i2f (
                .in_i (ext_in_data[i*IWID +: IWID]),
                .out_o(cvt)
            );
        end else begin : g_raw
            assign cvt = ext_in_data[i*IWID +: IWID];
        end
        fl_io_chan #(.W(FW)) u_chan (
            .clk      (clk),
            .rst_n    (rst),
            .load_i   (in_load[i]),
            .data_i   (cvt),
            .consume_i(rd_en[i]),
            .data_o   (in_word[i]),
            .vld_o    (in_vld[i]),
            .rdy_o    (in_rdy[i])
        );
    end

    for (genvar j = 0; j < NUIOOU; j++) begin : g_out
        logic [OWID-1:0] cvt;
        if (CONV != 0) begin : g_cv
            float2int #(.NBMANT(NBMANT), .NBEXPO(NBEXPO), .OWID(OWID)) u_f2i (
                .in_i (proc_out_data),
                .out_o(cvt)
            );
        end else begin : g_raw
            assign cvt = proc_out_data;
        end
        fl_io_chan #(.W(OWID)) u_chan (
            .clk      (clk),
            .rst_n    (rst),
            .load_i   (wr_en[j]),
            .data_i   (cvt),
            .consume_i(out_drain[j]),
            .data_o   (out_word[j]),
            .vld_o    (out_vld[j]),
            .rdy_o    (out_rdy[j])
        );
        assign ext_out_data[j*OWID +: OWID] = out_word[j];
    end

    // Address decode by explicit match so non-power-of-2 counts never index past the arrays.
    always_comb begin
        in_ok       = 1'b0;
        in_sel_vld  = 1'b0;
        in_sel_data = '0;
        for (int unsigned i = 0; i < NUIOIN; i++) begin
            if (proc_addr_in == AWI'(i)) begin
                in_ok       = 1'b1;
                in_sel_vld  = in_vld[i];
                in_sel_data = in_word[i];
            end
        end
        out_ok      = 1'b0;
        out_sel_rdy = 1'b0;
        for (int unsigned j = 0; j < NUIOOU; j++) begin
            if (proc_addr_out == AWO'(j)) begin
                out_ok      = 1'b1;
                out_sel_rdy = out_rdy[j];
            end
        end

        read_stall  = proc_req_in & in_ok & ~in_sel_vld;
        write_stall = proc_out_en & out_ok & ~out_sel_rdy;
        stall       = rst & (read_stall | write_stall);
        // Either side stalling blocks both, so the core can simply replay the whole cycle.
        go          = rst & ~stall;

        rd_en = '0;
        for (int unsigned i = 0; i < NUIOIN; i++) begin
            rd_en[i] = go & proc_req_in & (proc_addr_in == AWI'(i));
        end
        wr_en = '0;
        for (int unsigned j = 0; j < NUIOOU; j++) begin
            wr_en[j] = go & proc_out_en & (proc_addr_out == AWO'(j));
        end

        err_hit    = go & ((proc_req_in & ~in_ok) | (proc_out_en & ~out_ok));
        addr_err_d = addr_err_q | err_hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) addr_err_q <= 1'b0;
        else      addr_err_q <= addr_err_d;
    end

    assign proc_in_data = in_sel_data;
    assign proc_stall   = stall;
    assign ext_out_vld  = out_vld;
    assign addr_err     = addr_err_q;

endmodule

// File: tb/tb_fl_io_bridge.sv
// Bench for fl_io_bridge: a default CONV=1 build, a three-channel build and a CONV=0 build.
// Reads and output drains are checked by a monitor against expectation queues.
module tb_fl_io_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // Default build: 4 in / 4 out, CONV=1
    logic [4*19-1:0] in_data;
    logic [3:0]      in_vld, in_rdy;
    logic            req;
    logic [1:0]      raddr;
    logic [27:0]     rdata;
    logic            wen;
    logic [1:0]      waddr;
    logic [27:0]     wdata;
    logic            stall;
    logic [4*28-1:0] out_data;
    logic [3:0]      out_vld, out_rdy;
    logic            aerr;

    fl_io_bridge #(.NBMANT(19), .NBEXPO(8), .NUIOIN(4), .NUIOOU(4), .IWID(19), .OWID(28), .CONV(1)) dut (
        .clk(clk), .rst(rst), .ext_in_data(in_data), .ext_in_vld(in_vld), .ext_in_rdy(in_rdy),
        .proc_req_in(req), .proc_addr_in(raddr), .proc_in_data(rdata),
        .proc_out_en(wen), .proc_addr_out(waddr), .proc_out_data(wdata), .proc_stall(stall),
        .ext_out_data(out_data), .ext_out_vld(out_vld), .ext_out_rdy(out_rdy), .addr_err(aerr)
    );

    // Three-channel build
    logic [3*19-1:0] in_data3;
    logic [2:0]      in_vld3, in_rdy3;
    logic            req3;
    logic [1:0]      raddr3;
    logic [27:0]     rdata3;
    logic            wen3;
    logic [1:0]      waddr3;
    logic [27:0]     wdata3;
    logic            stall3;
    logic [3*28-1:0] out_data3;
    logic [2:0]      out_vld3, out_rdy3;
    logic            aerr3;

    fl_io_bridge #(.NBMANT(19), .NBEXPO(8), .NUIOIN(3), .NUIOOU(3), .IWID(19), .OWID(28), .CONV(1)) dut3 (
        .clk(clk), .rst(rst), .ext_in_data(in_data3), .ext_in_vld(in_vld3), .ext_in_rdy(in_rdy3),
        .proc_req_in(req3), .proc_addr_in(raddr3), .proc_in_data(rdata3),
        .proc_out_en(wen3), .proc_addr_out(waddr3), .proc_out_data(wdata3), .proc_stall(stall3),
        .ext_out_data(out_data3), .ext_out_vld(out_vld3), .ext_out_rdy(out_rdy3), .addr_err(aerr3)
    );

    // Raw passthrough build, core loops the read word back to the write port
    logic [4*28-1:0] in_data0;
    logic [3:0]      in_vld0, in_rdy0;
    logic            req0;
    logic [1:0]      raddr0;
    logic [27:0]     rdata0;
    logic            wen0;
    logic [1:0]      waddr0;
    logic [27:0]     wdata0;
    logic            stall0;
    logic [4*28-1:0] out_data0;
    logic [3:0]      out_vld0, out_rdy0;
    logic            aerr0;

    assign wdata0 = rdata0;

    fl_io_bridge #(.NBMANT(19), .NBEXPO(8), .NUIOIN(4), .NUIOOU(4), .IWID(28), .OWID(28), .CONV(0)) dut0 (
        .clk(clk), .rst(rst), .ext_in_data(in_data0), .ext_in_vld(in_vld0), .ext_in_rdy(in_rdy0),
        .proc_req_in(req0), .proc_addr_in(raddr0), .proc_in_data(rdata0),
        .proc_out_en(wen0), .proc_addr_out(waddr0), .proc_out_data(wdata0), .proc_stall(stall0),
        .ext_out_data(out_data0), .ext_out_vld(out_vld0), .ext_out_rdy(out_rdy0), .addr_err(aerr0)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          ch;
        logic [27:0] d;
    } oexp_t;

    logic [27:0] rd_q [$];
    oexp_t       out_q [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted read and every output drain must match the next expectation.
    always @(negedge clk) begin : monitor
        logic [27:0] e;
        oexp_t       oe;
        if (rst === 1'b1) begin
            if (req && !stall) begin
                if (rd_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rd_unexpected: got %h expected no read", rdata);
                end else begin
                    e = rd_q.pop_front();
                    chk("rd_data", 64'(rdata), 64'(e));
                end
            end
            for (int j = 0; j < 4; j++) begin
                if (out_vld[j] && out_rdy[j]) begin
                    if (out_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL drain_unexpected: got ch %0d data %h expected none", j, out_data[j*28 +: 28]);
                    end else begin
                        oe = out_q.pop_front();
                        chk("drain_ch", 64'(j), 64'(oe.ch));
                        chk("drain_data", 64'(out_data[j*28 +: 28]), 64'(oe.d));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        in_data = '0;  in_vld = '0;  req = 1'b0;  raddr = '0;  wen = 1'b0;  waddr = '0;  wdata = '0;  out_rdy = '0;
        in_data3 = '0; in_vld3 = '0; req3 = 1'b0; raddr3 = '0; wen3 = 1'b0; waddr3 = '0; wdata3 = '0; out_rdy3 = '0;
        in_data0 = '0; in_vld0 = '0; req0 = 1'b0; raddr0 = '0; wen0 = 1'b0; waddr0 = '0; out_rdy0 = '0;

        // Reset state
        smp();
        chk("rst_in_rdy", 64'(in_rdy), 64'h0);
        chk("rst_stall", 64'(stall), 64'h0);
        chk("rst_out_vld", 64'(out_vld), 64'h0);
        chk("rst_addr_err", 64'(aerr), 64'h0);
        chk("rst_out_data_nz", 64'(|out_data), 64'h0);
        step(); rst = 1'b1;
        smp();
        chk("rel_in_rdy", 64'(in_rdy), 64'hF);

        // Capture on ch2, read it back as int2float(5)
        step(); in_vld[2] = 1'b1; in_data[2*19 +: 19] = 19'd5;
        smp(); chk("t1_rdy_empty", 64'(in_rdy[2]), 64'h1);
        step(); in_vld = '0;
        smp(); chk("t1_rdy_full", 64'(in_rdy), 64'hB);
        step(); req = 1'b1; raddr = 2'd2; rd_q.push_back(28'h7850000);
        smp(); chk("t1_stall", 64'(stall), 64'h0); chk("t1_rdy_reading", 64'(in_rdy[2]), 64'h1);
        step(); req = 1'b0;
        smp(); chk("t1_rdy_after", 64'(in_rdy), 64'hF);

        // Read of empty ch1 stalls until the cycle after -7 is captured
        step(); req = 1'b1; raddr = 2'd1;
        smp(); chk("t2_stall_a", 64'(stall), 64'h1);
        step();
        smp(); chk("t2_stall_b", 64'(stall), 64'h1);
        step(); in_vld[1] = 1'b1; in_data[1*19 +: 19] = 19'h7FFF9; rd_q.push_back(28'hF870000);
        smp(); chk("t2_stall_capt", 64'(stall), 64'h1);
        step(); in_vld = '0;
        smp(); chk("t2_stall_drop", 64'(stall), 64'h0);
        step(); req = 1'b0;
        smp(); chk("t2_rdy_after", 64'(in_rdy), 64'hF);

        // Read and capture in the same cycle on ch0: old word returned, new word kept
        step(); in_vld[0] = 1'b1; in_data[0 +: 19] = 19'd1;
        smp();
        step(); in_data[0 +: 19] = 19'd3; req = 1'b1; raddr = 2'd0; rd_q.push_back(28'h7740000);
        smp(); chk("sim_stall", 64'(stall), 64'h0); chk("sim_rdy", 64'(in_rdy[0]), 64'h1);
        step(); in_vld = '0; rd_q.push_back(28'h77E0000);
        smp(); chk("sim_stall2", 64'(stall), 64'h0);
        step(); req = 1'b0;
        smp(); chk("sim_rdy_after", 64'(in_rdy), 64'hF);

        // Output ch3: 100.0 held, second write stalls until drain, then lands with it
        step(); wen = 1'b1; waddr = 2'd3; wdata = 28'h7A64000;
        smp(); chk("t3_stall_first", 64'(stall), 64'h0);
        step(); wdata = 28'hF870000;
        smp();
        chk("t3_vld", 64'(out_vld[3]), 64'h1);
        chk("t3_data", 64'(out_data[3*28 +: 28]), 64'd100);
        chk("t3_stall_full", 64'(stall), 64'h1);
        step();
        smp(); chk("t3_stall_hold", 64'(stall), 64'h1); chk("t3_data_hold", 64'(out_data[3*28 +: 28]), 64'd100);
        step(); out_rdy[3] = 1'b1; out_q.push_back('{3, 28'd100});
        smp(); chk("t3_stall_drain", 64'(stall), 64'h0);
        step(); wen = 1'b0; out_q.push_back('{3, 28'hFFFFFF9});
        smp(); chk("t3_vld_second", 64'(out_vld[3]), 64'h1);
        step(); out_rdy[3] = 1'b0;
        smp(); chk("t3_vld_empty", 64'(out_vld), 64'h0);

        // Saturation both ways on ch0, written back-to-back while draining
        step(); out_rdy[0] = 1'b1; wen = 1'b1; waddr = 2'd0; wdata = 28'h0A40000; out_q.push_back('{0, 28'h7FFFFFF});
        smp(); chk("sat_stall_a", 64'(stall), 64'h0);
        step(); wdata = 28'h8A40000; out_q.push_back('{0, 28'h8000000});
        smp(); chk("sat_stall_b", 64'(stall), 64'h0);
        step(); wen = 1'b0;
        smp();
        step(); out_rdy = '0;
        smp(); chk("sat_vld_empty", 64'(out_vld), 64'h0);

        // Three-channel build: address 3 does not exist
        step(); in_vld3[0] = 1'b1; in_data3[0 +: 19] = 19'd5;
        smp();
        step(); in_vld3 = '0; req3 = 1'b1; raddr3 = 2'd3;
        smp();
        chk("t4_stall", 64'(stall3), 64'h0);
        chk("t4_data", 64'(rdata3), 64'h0);
        chk("t4_err_before", 64'(aerr3), 64'h0);
        step(); req3 = 1'b0; wen3 = 1'b1; waddr3 = 2'd3; wdata3 = 28'h7A64000;
        smp(); chk("t4_err_set", 64'(aerr3), 64'h1); chk("t4_wstall", 64'(stall3), 64'h0);
        step(); wen3 = 1'b0;
        smp();
        chk("t4_wr_dropped", 64'(out_vld3), 64'h0);
        chk("t4_err_sticky", 64'(aerr3), 64'h1);
        chk("t4_ch0_kept", 64'(in_rdy3), 64'h6);

        // Raw build: in->out round trip, read and write in one cycle
        step(); in_vld0[0] = 1'b1; in_data0[0 +: 28] = 28'hA5A5A5A;
        smp();
        step(); in_vld0 = '0; req0 = 1'b1; raddr0 = 2'd0; wen0 = 1'b1; waddr0 = 2'd2;
        smp(); chk("t6_stall", 64'(stall0), 64'h0); chk("t6_rdata", 64'(rdata0), 64'hA5A5A5A);
        step(); req0 = 1'b0; wen0 = 1'b0;
        smp(); chk("t6_vld", 64'(out_vld0), 64'h4); chk("t6_out", 64'(out_data0[2*28 +: 28]), 64'hA5A5A5A);

        // Fill everything, stall, then reset mid-stall
        step(); in_vld = 4'hF; wen = 1'b1; waddr = 2'd0; wdata = 28'h7A64000;
        smp();
        step(); in_vld = '0; waddr = 2'd1;
        smp();
        step(); waddr = 2'd2;
        smp();
        step(); waddr = 2'd3;
        smp();
        step(); waddr = 2'd1;
        smp();
        chk("t5_stall_full", 64'(stall), 64'h1);
        chk("t5_in_full", 64'(in_rdy), 64'h0);
        chk("t5_out_full", 64'(out_vld), 64'hF);
        step(); rst = 1'b0;
        smp();
        chk("t5_rst_in_rdy", 64'(in_rdy), 64'h0);
        chk("t5_rst_out_vld", 64'(out_vld), 64'h0);
        chk("t5_rst_stall", 64'(stall), 64'h0);
        chk("t5_rst_out_data_nz", 64'(|out_data), 64'h0);
        chk("t5_rst_err3", 64'(aerr3), 64'h0);
        chk("t5_rst_vld0", 64'(out_vld0), 64'h0);
        step();
        smp(); chk("t5_rst_stall_hold", 64'(stall), 64'h0);
        step(); rst = 1'b1; wen = 1'b0;
        smp();
        chk("t5_rel_in_rdy", 64'(in_rdy), 64'hF);
        chk("t5_rel_stall", 64'(stall), 64'h0);
        chk("t5_rel_err3", 64'(aerr3), 64'h0);
        step(); req = 1'b1; raddr = 2'd0;
        smp(); chk("t5_empty_stall", 64'(stall), 64'h1);
        step(); req = 1'b0;
        smp();

        chk("main_addr_err", 64'(aerr), 64'h0);
        chk("rd_q_left", 64'(rd_q.size()), 64'h0);
        chk("out_q_left", 64'(out_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
